// File: rtl/multi_alarm_clock.sv
// Multi-channel alarm clock: running 24h time, set/shadow FSM, 12h display,
// per-channel alarms with lowest-index priority and a minute-based snooze.
module multi_alarm_clock #(
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned SNOOZE_MIN = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pulsed_set,
    input  logic                    pulsed_up,
    input  logic                    pulsed_down,
    input  logic [5*NUM_ALARMS-1:0] alarm_hours,
    input  logic [6*NUM_ALARMS-1:0] alarm_minutes,
    input  logic [NUM_ALARMS-1:0]   alarm_enable,
    output logic [4:0]              hours,
    output logic [5:0]              minutes,
    output logic [5:0]              seconds,
    output logic [3:0]              disp_hours,
    output logic                    disp_pm,
    output logic                    disp_12h,
    output logic [1:0]              set_state,
    output logic                    alarm_alert,
    output logic [2:0]              alarm_id,
    output logic                    snooze_active
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SET_HOUR = 2'd1,
        S_SET_MIN  = 2'd2
    } state_t;

    state_t             r_state, w_next_state;
    logic [DIV_W-1:0]   r_div;
    logic [4:0]         r_hours, r_sh_hour, w_next_hour, w_src_hour;
    logic [5:0]         r_minutes, r_seconds, r_sh_min, w_next_min;
    logic [5:0]         r_snz_cnt;
    logic               r_12h, r_alert, r_snooze;
    logic [2:0]         r_id, w_match_idx;

    logic w_set, w_down, w_up, w_tick, w_sec_wrap, w_match;
    logic w_commit, w_load_shadow, w_snooze_start, w_dismiss, w_toggle;
    logic w_hr_inc, w_hr_dec, w_min_inc, w_min_dec;

    // Only the highest-priority pulse is acted upon
    assign w_set  = pulsed_set;
    assign w_down = pulsed_down & ~pulsed_set;
    assign w_up   = pulsed_up & ~pulsed_set & ~pulsed_down;

    assign w_tick      = (r_div == DIV_W'(TICK_DIV - 1));
    assign w_sec_wrap  = w_tick & (r_seconds == 6'd59) & ~w_commit;
    assign w_next_min  = (r_minutes == 6'd59) ? 6'd0 : r_minutes + 6'd1;
    assign w_next_hour = (r_minutes != 6'd59) ? r_hours :
                         (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state   = r_state;
        w_commit       = 1'b0;
        w_load_shadow  = 1'b0;
        w_snooze_start = 1'b0;
        w_dismiss      = 1'b0;
        w_toggle       = 1'b0;
        w_hr_inc       = 1'b0;
        w_hr_dec       = 1'b0;
        w_min_inc      = 1'b0;
        w_min_dec      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_set) begin
                    if (r_alert) begin
                        w_snooze_start = 1'b1;
                    end else begin
                        w_load_shadow = 1'b1;
                        w_next_state  = S_SET_HOUR;
                    end
                end else if (w_down) begin
                    w_dismiss = r_alert;
                end else if (w_up) begin
                    w_toggle = ~r_alert;
                end
            end
            S_SET_HOUR: begin
                if (w_set)       w_next_state = S_SET_MIN;
                else if (w_down) w_hr_dec = 1'b1;
                else if (w_up)   w_hr_inc = 1'b1;
            end
            S_SET_MIN: begin
                if (w_set) begin
                    w_commit     = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_down) begin
                    w_min_dec = 1'b1;
                end else if (w_up) begin
                    w_min_inc = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Running time; a commit overrides any tick landing in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div     <= '0;
            r_hours   <= '0;
            r_minutes <= '0;
            r_seconds <= '0;
        end else if (w_commit) begin
            r_div     <= '0;
            r_hours   <= r_sh_hour;
            r_minutes <= r_sh_min;
            r_seconds <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_tick) begin
                if (r_seconds == 6'd59) begin
                    r_seconds <= '0;
                    r_minutes <= w_next_min;
                    r_hours   <= w_next_hour;
                end else begin
                    r_seconds <= r_seconds + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sh_hour <= '0;
            r_sh_min  <= '0;
            r_12h     <= 1'b0;
        end else begin
            if (w_load_shadow) begin
                r_sh_hour <= r_hours;
                r_sh_min  <= r_minutes;
            end
            if (w_hr_inc) r_sh_hour <= (r_sh_hour == 5'd23) ? 5'd0 : r_sh_hour + 5'd1;
            if (w_hr_dec) r_sh_hour <= (r_sh_hour == 5'd0) ? 5'd23 : r_sh_hour - 5'd1;
            if (w_min_inc) r_sh_min <= (r_sh_min == 6'd59) ? 6'd0 : r_sh_min + 6'd1;
            if (w_min_dec) r_sh_min <= (r_sh_min == 6'd0) ? 6'd59 : r_sh_min - 6'd1;
            if (w_toggle) r_12h <= ~r_12h;
        end
    end

    // Lowest enabled channel matching the post-tick time wins
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = 3'd0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (alarm_enable[i] && alarm_hours[5*i +: 5] == w_next_hour &&
                alarm_minutes[6*i +: 6] == w_next_min) begin
                w_match     = 1'b1;
                w_match_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alert   <= 1'b0;
            r_id      <= '0;
            r_snooze  <= 1'b0;
            r_snz_cnt <= '0;
        end else if (w_dismiss) begin
            r_alert   <= 1'b0;
            r_snooze  <= 1'b0;
            r_snz_cnt <= '0;
        end else if (w_snooze_start) begin
            r_alert   <= 1'b0;
            r_snooze  <= 1'b1;
            r_snz_cnt <= 6'(SNOOZE_MIN);
        end else begin
            if (w_sec_wrap && w_match && !r_alert) begin
                r_alert <= 1'b1;
                r_id    <= w_match_idx;
            end
            if (r_snooze && w_sec_wrap) begin
                if (r_snz_cnt == 6'd1) begin
                    r_alert   <= 1'b1;
                    r_snooze  <= 1'b0;
                    r_snz_cnt <= '0;
                end else begin
                    r_snz_cnt <= r_snz_cnt - 6'd1;
                end
            end
        end
    end

    assign w_src_hour = (r_state == S_IDLE) ? r_hours : r_sh_hour;

    always_comb begin
        disp_hours = 4'd0;
        disp_pm    = 1'b0;
        if (r_12h) begin
            if (w_src_hour == 5'd0) begin
                disp_hours = 4'd12;
            end else if (w_src_hour < 5'd12) begin
                disp_hours = 4'(w_src_hour);
            end else if (w_src_hour == 5'd12) begin
                disp_hours = 4'd12;
                disp_pm    = 1'b1;
            end else begin
                disp_hours = 4'(w_src_hour - 5'd12);
                disp_pm    = 1'b1;
            end
        end
    end

    assign hours         = r_hours;
    assign minutes       = r_minutes;
    assign seconds       = r_seconds;
    assign disp_12h      = r_12h;
    assign set_state     = r_state;
    assign alarm_alert   = r_alert;
    assign alarm_id      = r_id;
    assign snooze_active = r_snooze;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock with TICK_DIV=4, SNOOZE_MIN=2, NUM_ALARMS=4.
module tb_multi_alarm_clock;

    logic        clk, reset;
    logic        pulsed_set, pulsed_up, pulsed_down;
    logic [19:0] alarm_hours;
    logic [23:0] alarm_minutes;
    logic [3:0]  alarm_enable;
    logic [4:0]  hours;
    logic [5:0]  minutes, seconds;
    logic [3:0]  disp_hours;
    logic        disp_pm, disp_12h;
    logic [1:0]  set_state;
    logic        alarm_alert;
    logic [2:0]  alarm_id;
    logic        snooze_active;

    int n_cmp = 0;
    int n_err = 0;

    multi_alarm_clock #(.NUM_ALARMS(4), .TICK_DIV(4), .SNOOZE_MIN(2)) dut (
        .clk(clk), .reset(reset),
        .pulsed_set(pulsed_set), .pulsed_up(pulsed_up), .pulsed_down(pulsed_down),
        .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes), .alarm_enable(alarm_enable),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .disp_hours(disp_hours), .disp_pm(disp_pm), .disp_12h(disp_12h),
        .set_state(set_state), .alarm_alert(alarm_alert), .alarm_id(alarm_id),
        .snooze_active(snooze_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle pulse, sampled by exactly one rising edge
    task automatic pulse(input bit s, input bit d, input bit u);
        pulsed_set  = s;
        pulsed_down = d;
        pulsed_up   = u;
        @(posedge clk);
        #1;
        pulsed_set  = 1'b0;
        pulsed_down = 1'b0;
        pulsed_up   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; pulsed_set = 0; pulsed_up = 0; pulsed_down = 0;
        alarm_hours = '0; alarm_minutes = '0; alarm_enable = '0;
        #1;
        check("rst_hours", hours, 0);
        check("rst_state", set_state, 0);
        check("rst_alert", alarm_alert, 0);

        // Wrap, shadow wrap, commit collision with a tick
        do_reset();
        pulse(0, 0, 1);
        check("t1_12h_on", disp_12h, 1);
        check("t1_disp_midnight", disp_hours, 12);
        pulse(1, 0, 0);
        check("t1_state_hour", set_state, 1);
        pulse(0, 1, 0);
        check("t1_sh_hour_wrap_disp", disp_hours, 11);
        check("t1_sh_hour_wrap_pm", disp_pm, 1);
        pulse(1, 0, 0);
        check("t1_state_min", set_state, 2);
        check("t1_running_sec", seconds, 1);
        pulse(0, 1, 0);
        pulse(0, 0, 1);
        pulse(0, 1, 0);
        pulse(1, 0, 0);
        check("t1_commit_h", hours, 23);
        check("t1_commit_m", minutes, 59);
        check("t1_commit_s", seconds, 0);
        check("t1_commit_state", set_state, 0);
        step(3);
        check("t1_div_clear_a", seconds, 0);
        step(1);
        check("t1_div_clear_b", seconds, 1);
        step(232);
        check("t1_pre_s", seconds, 59);
        check("t1_pre_h", hours, 23);
        step(4);
        check("t1_wrap_h", hours, 0);
        check("t1_wrap_m", minutes, 0);
        check("t1_wrap_s", seconds, 0);
        check("t1_wrap_disp", disp_hours, 12);
        check("t1_wrap_pm", disp_pm, 0);

        // Priority, snooze, dismiss
        alarm_hours   = '0;
        alarm_minutes = {6'd1, 6'd1, 6'd1, 6'd5};
        alarm_enable  = 4'b1010;
        do_reset();
        step(239);
        check("t2_pre_alert", alarm_alert, 0);
        step(1);
        check("t2_alert", alarm_alert, 1);
        check("t2_id", alarm_id, 1);
        check("t2_min", minutes, 1);
        pulse(1, 1, 0);
        check("t2_snz_alert", alarm_alert, 0);
        check("t2_snz_active", snooze_active, 1);
        check("t2_snz_state", set_state, 0);
        alarm_enable = 4'b0000;
        step(239);
        check("t2_carry1_alert", alarm_alert, 0);
        check("t2_carry1_snz", snooze_active, 1);
        step(239);
        check("t2_pre_re_alert", alarm_alert, 0);
        step(1);
        check("t2_re_alert", alarm_alert, 1);
        check("t2_re_id", alarm_id, 1);
        check("t2_re_snz", snooze_active, 0);
        pulse(0, 1, 0);
        check("t2_dismiss", alarm_alert, 0);

        // Commit collision must not raise an alarm
        alarm_hours   = {5'd0, 5'd0, 5'd0, 5'd7};
        alarm_minutes = {6'd0, 6'd0, 6'd0, 6'd30};
        alarm_enable  = 4'b0001;
        do_reset();
        pulse(1, 0, 0);
        repeat (7) pulse(0, 0, 1);
        pulse(1, 0, 0);
        repeat (30) pulse(0, 0, 1);
        check("t3_running_sec", seconds, 9);
        pulse(1, 0, 0);
        check("t3_h", hours, 7);
        check("t3_m", minutes, 30);
        check("t3_s", seconds, 0);
        check("t3_alert", alarm_alert, 0);
        step(3);
        check("t3_div_a", seconds, 0);
        step(1);
        check("t3_div_b", seconds, 1);
        check("t3_alert_late", alarm_alert, 0);

        // Reset during SET_MIN aborts without commit
        alarm_enable = '0;
        do_reset();
        pulse(1, 0, 0);
        repeat (3) pulse(0, 0, 1);
        pulse(1, 0, 0);
        repeat (2) pulse(0, 0, 1);
        check("t4_state_min", set_state, 2);
        reset = 1'b0;
        #1;
        check("t4_rst_state", set_state, 0);
        check("t4_rst_s", seconds, 1 - 1);
        check("t4_rst_disp12", disp_12h, 0);
        check("t4_rst_snz", snooze_active, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        step(3);
        check("t4_first_tick_a", seconds, 0);
        step(1);
        check("t4_first_tick_b", seconds, 1);
        check("t4_no_commit_h", hours, 0);
        check("t4_no_commit_m", minutes, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_alarm_clock.md
MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 Parameter NUM_ALARMS, default 4, number of independent alarm channels (1..8) SHALL be supported.
REQ-002 Parameter TICK_DIV, default 50000000, clk cycles per second; the block SHALL support any value >= 2.
REQ-003 Parameter SNOOZE_MIN, default 5, snooze length in whole minutes; the block SHALL support 1..59.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset; signals are listed below.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous active-low reset.
- pulsed_set  in  1  single-cycle set/snooze pulse.
- pulsed_up  in  1  single-cycle up pulse.
- pulsed_down  in  1  single-cycle down/dismiss pulse.
- alarm_hours  in  5*NUM_ALARMS  packed alarm hours, channel i at [5i+4:5i], 0..23.
- alarm_minutes  in  6*NUM_ALARMS  packed alarm minutes, channel i at [6i+5:6i], 0..59.
- alarm_enable  in  NUM_ALARMS  per-channel enable.
- hours  out  5  running time, 24h binary.
- minutes  out  6  running time.
- seconds  out  6  running time.
- disp_hours  out  4  displayed hour: 0..23 truncated not allowed, see REQ-019.
- disp_pm  out  1  PM flag, valid in 12h mode, else 0.
- disp_12h  out  1  1 = 12h display mode.
- set_state  out  2  0 IDLE, 1 SET_HOUR, 2 SET_MIN.
- alarm_alert  out  1  alarm sounding.
- alarm_id  out  3  index of channel that raised the alert.
- snooze_active  out  1  snooze countdown running.

Function
REQ-005 A divider SHALL count 0..TICK_DIV-1. The cycle where it equals TICK_DIV-1 is a tick and the divider returns to 0.
REQ-006 On each tick, seconds SHALL increment. Carry rules:
- 59 -> 0 carries into minutes.
- minutes 59 -> 0 carries into hours.
- 23:59:59 wraps to 00:00:00.
REQ-007 The running time SHALL keep counting in every set_state.
REQ-008 Set state machine:
- IDLE + pulsed_set with alarm_alert=0: go to SET_HOUR and load shadow hour/minute from the running time.
- SET_HOUR + pulsed_set: go to SET_MIN.
- SET_MIN + pulsed_set: commit, then go to IDLE.
REQ-009 On commit, hours/minutes SHALL load from the shadow, and seconds and divider SHALL clear to 0. If a tick falls in the commit cycle, the commit wins and the tick is discarded.
REQ-010 In SET_HOUR, up/down SHALL adjust the shadow hour mod 24 (23 up -> 0, 0 down -> 23). In SET_MIN, up/down SHALL adjust the shadow minute mod 60.
REQ-011 In IDLE with alarm_alert=0, pulsed_up SHALL toggle disp_12h.
REQ-012 Alarm match: evaluated only on a tick that makes seconds 0. Channel i matches when alarm_enable[i]=1 and its hour/minute equal the post-tick hours/minutes.
REQ-013 On a match while alarm_alert=0, alarm_alert SHALL rise on the cycle after the tick. alarm_id SHALL take the lowest matching index.
REQ-014 A commit SHALL never raise an alert, even if the committed time matches an alarm.
REQ-015 While alarm_alert=1, further matches SHALL be ignored and alarm_id SHALL hold.
REQ-016 Dismiss: pulsed_down in IDLE with alarm_alert=1 SHALL clear alarm_alert and snooze_active on the next cycle.
REQ-017 Snooze: pulsed_set in IDLE with alarm_alert=1 SHALL:
- clear alarm_alert;
- set snooze_active;
- load the snooze counter with SNOOZE_MIN;
- not enter SET_HOUR.
REQ-018 The snooze counter SHALL decrement on each minute carry. When it reaches 0, alarm_alert SHALL reassert with the stored alarm_id and snooze_active SHALL clear, independent of alarm_enable. Entering SET_HOUR SHALL NOT cancel a pending snooze.
REQ-019 The displayed source is the running time in IDLE and the shadow in SET states.
- disp_12h=0: disp_hours = displayed hour mod 16 is forbidden; a 24h view SHALL be taken from hours, and disp_hours SHALL be 0 with disp_pm=0.
- disp_12h=1: hour 0 -> 12 AM; 1..11 -> same AM; 12 -> 12 PM; 13..23 -> h-12 PM.
- disp_hours and disp_pm SHALL be combinational from the registered source.
REQ-020 Simultaneous pulses SHALL have priority pulsed_set > pulsed_down > pulsed_up; only the highest is acted upon.

Reset
REQ-021 While reset=0, the following SHALL be 0: divider, hours, minutes, seconds, shadow, set_state (IDLE), disp_12h, alarm_alert, alarm_id, snooze_active, snooze counter.
REQ-022 Reset asserted mid-set or mid-snooze SHALL abort without commit. The first tick after release SHALL occur TICK_DIV cycles after the first clk edge with reset=1.

Verification (TICK_DIV=4, SNOOZE_MIN=2, NUM_ALARMS=4)
REQ-023 Wrap: commit 23:59 and run 60 ticks -> hours/minutes/seconds = 00:00:00; disp_12h=1 -> disp_hours=12, disp_pm=0.
REQ-024 Priority: alarms 1 and 3 both enabled at 00:01, start 00:00:00 -> alarm_alert=1 one cycle after the 60th tick, alarm_id=1; channel 3 is ignored.
REQ-025 Snooze: during the alert, pulsed_set -> alert drops and snooze_active=1. Two minute carries later -> alarm_alert=1, alarm_id unchanged, snooze_active=0.
REQ-026 Commit collision: in SET_MIN, shadow 07:30, pulsed_set in the same cycle as a tick -> time 07:30:00, divider 0. Alarm 0 at 07:30 enabled -> no alert.
REQ-027 Shadow wrap: in SET_HOUR, pulsed_down from 0 -> shadow hour 23. In SET_MIN, pulsed_up from 59 -> shadow minute 0. Running time keeps ticking throughout.
REQ-028 Mid-set reset: reset=0 in SET_MIN with the shadow changed -> all outputs 0, set_state=0, and no commit after release.
